// File: rtl/conv_enc_213_framer.sv
// Frame-based (2,1,3) convolutional encoder: FRAME_LEN info bits plus 3 zero
// tail bits per frame, one registered 2-bit symbol per bit under valid/ready.
module conv_enc_213_framer #(
    parameter int         FRAME_LEN = 64,
    parameter int         LEN_W     = 8,
    parameter logic [3:0] G0        = 4'b1101,
    parameter logic [3:0] G1        = 4'b1111
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    output logic       busy,
    input  logic       din,
    input  logic       din_valid,
    output logic       din_ready,
    output logic [1:0] Rx_out,
    output logic       Rx_valid,
    input  logic       Rx_ready,
    output logic       frame_done
);

    typedef enum logic [1:0] {IDLE, DATA, TAIL, FLUSH} state_t;

    state_t           r_state;
    logic [2:0]       r_sr;        // {s0,s1,s2}, s0 is the most recent bit
    logic [LEN_W-1:0] r_bit_cnt;
    logic [1:0]       r_tail_cnt;
    logic [1:0]       r_rx;
    logic             r_valid;
    logic             r_done;

    logic             w_free;
    logic             w_u;
    logic [3:0]       w_v;
    logic [1:0]       w_sym;
    logic             w_last_bit;

    assign w_free     = !r_valid || Rx_ready;
    // Tail bits are forced to zero so the trellis ends in state 0.
    assign w_u        = (r_state == DATA) ? din : 1'b0;
    assign w_v        = {w_u, r_sr};
    assign w_sym      = {^(G0 & w_v), ^(G1 & w_v)};
    assign w_last_bit = (r_bit_cnt == LEN_W'(FRAME_LEN - 1));

    assign busy       = (r_state != IDLE);
    assign din_ready  = (r_state == DATA) && w_free;
    assign Rx_out     = r_rx;
    assign Rx_valid   = r_valid;
    assign frame_done = r_done;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_sr       <= '0;
            r_bit_cnt  <= '0;
            r_tail_cnt <= '0;
            r_rx       <= '0;
            r_valid    <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            // Drain first; a load below in the same cycle overrides it.
            if (r_valid && Rx_ready)
                r_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_sr       <= '0;
                        r_bit_cnt  <= '0;
                        r_tail_cnt <= '0;
                        r_state    <= DATA;
                    end
                end
                DATA: begin
                    if (din_valid && w_free) begin
                        r_rx      <= w_sym;
                        r_valid   <= 1'b1;
                        r_sr      <= {w_u, r_sr[2:1]};
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        if (w_last_bit)
                            r_state <= TAIL;
                    end
                end
                TAIL: begin
                    if (w_free) begin
                        r_rx       <= w_sym;
                        r_valid    <= 1'b1;
                        r_sr       <= {w_u, r_sr[2:1]};
                        r_tail_cnt <= r_tail_cnt + 1'b1;
                        if (r_tail_cnt == 2'd2)
                            r_state <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (r_valid && Rx_ready) begin
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/conv_enc_213_framer.md
Name: conv_enc_213_framer

Overview:
Frame-based (2,1,3) convolutional encoder. It sits directly upstream of the (2,1,3) Viterbi decoder and produces the 2-bit symbols the decoder consumes on its Rx input.
For each frame it accepts FRAME_LEN information bits over a valid/ready handshake. It then appends 3 zero tail bits so the trellis terminates in state 0.
Output is one registered 2-bit symbol per accepted or tail bit, under valid/ready backpressure.

Parameters:
FRAME_LEN, 64, information bits per frame (legal range 1..2^LEN_W-1).
LEN_W, 8, width of the bit counter.
G0, 4'b1101, generator for Rx_out[1]; bit3 taps u, bit2 taps s0, bit1 taps s1, bit0 taps s2.
G1, 4'b1111, generator for Rx_out[0]; same tap order as G0.

Ports:
clock  in  1  single clock; all state changes on the rising edge.
reset  in  1  asynchronous, active-low reset.
start  in  1  pulse: begin a new frame (honoured only in IDLE).
busy  out  1  high whenever state != IDLE.
din  in  1  information bit.
din_valid  in  1  din is valid.
din_ready  out  1  encoder accepts din this cycle.
Rx_out  out  2  encoded symbol {c0,c1}, connects to the decoder Rx.
Rx_valid  out  1  Rx_out holds a valid symbol.
Rx_ready  in  1  consumer takes Rx_out this cycle.
frame_done  out  1  one-cycle pulse when the last tail symbol is accepted downstream.

Behaviour:
- Reset (reset==0, asynchronous):
  - State IDLE; shift register s0,s1,s2 = 0; bit count = 0; tail count = 0.
  - Rx_out = 2'b00; Rx_valid = 0; frame_done = 0; busy = 0; din_ready = 0.
- Encoding of an input bit u (vector v = {u,s0,s1,s2}):
  - c0 = XOR-reduce(G0 & v), c1 = XOR-reduce(G1 & v).
  - After encoding: s2 <= s1, s1 <= s0, s0 <= u.
- Output register and handshake:
  - Output register is free when (!Rx_valid || Rx_ready).
  - Rx_out/Rx_valid hold stable while Rx_valid && !Rx_ready.
  - An accepted symbol drains when Rx_valid && Rx_ready, or is replaced the same cycle by the next symbol.
- FSM states: IDLE, DATA, TAIL, FLUSH.
- IDLE:
  - start=1: clear s0..s2, bit count and tail count; go to DATA.
  - start while busy is ignored.
- DATA:
  - din_ready = free.
  - On din_valid && din_ready: load {c0,c1} into Rx_out, set Rx_valid, update the shift register, bit count += 1.
  - Rx_out is valid the cycle after acceptance (latency 1).
  - When the FRAME_LEN-th bit is accepted: go to TAIL.
- TAIL:
  - din_ready = 0.
  - Each cycle the register is free, encode u=0, load the symbol, tail count += 1.
  - After the 3rd tail symbol is loaded: go to FLUSH.
  - After the tail, s0..s2 == 0.
- FLUSH:
  - Wait for Rx_valid && Rx_ready on the final tail symbol.
  - That cycle: pulse frame_done (registered, high next cycle for exactly 1 cycle), go to IDLE.
  - Rx_valid drops unless a new frame overlaps (it cannot: start is ignored until IDLE).
- Throughput: with Rx_ready held high and din_valid high, 1 symbol per cycle, no bubbles between data and tail.
- din_valid with din_ready=0 has no effect; din is not sampled.
- Reset asserted mid-frame aborts immediately to the reset values; no partial flush, no frame_done.
- Total symbols per frame is exactly FRAME_LEN+3.

Test Plan:
- Known vector, FRAME_LEN=4, din 1,0,1,1, Rx_ready=1 -> Rx_out sequence 11,11,10,11,10,10,11; frame_done pulses once after the 7th symbol; busy falls to 0.
- Impulse, FRAME_LEN=1, din=1 -> 11,11,01,11; shift register 000 at frame end.
- Backpressure: known vector with Rx_ready toggling 1,0,0,1,... -> same 7 symbols, each held stable while stalled; din_ready low whenever the register is full and not draining; no symbol lost or duplicated.
- Input gaps: din_valid low for 3 cycles mid-frame -> no symbols emitted during the gap; output sequence unchanged.
- start while busy, and start pulse during FLUSH -> ignored; a start after returning to IDLE begins a fresh frame from state 000.
- Reset mid-frame after 2 accepted bits -> all outputs to reset values immediately; the next frame's output equals the known-vector result.
